// File: rtl/bcd_display_scanner_pkg.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner_pkg
//   Shared definitions for the BCD seven-segment display scanner.
//   - Active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - Scanner FSM state encoding
//   - seg_drive(): applies the board's segment polarity to a pattern
// ---------------------------------------------------------------------------
package bcd_display_scanner_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2
   } state_t;

   // Convert an active-high pattern to the pin level.
   function automatic logic [6:0] seg_drive(input logic [6:0] pattern,
                                            input bit active_low);
      return active_low ? ~pattern : pattern;
   endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner_if
//   Bundle between the BCD counter chain and the display scanner, plus the
//   display pin outputs.
//   master : drives enable, digits_in, dp_in, blank_lz; observes outputs
//   slave  : the scanner; consumes inputs, drives seg, dp, an, frame_start,
//            invalid
// ---------------------------------------------------------------------------
interface bcd_display_scanner_if #(
   parameter int NUM_DIGITS = 4
) ();

   logic                      enable;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      blank_lz;
   logic [6:0]                seg;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_start;
   logic                      invalid;

   modport master (
      output enable, digits_in, dp_in, blank_lz,
      input  seg, dp, an, frame_start, invalid
   );

   modport slave (
      input  enable, digits_in, dp_in, blank_lz,
      output seg, dp, an, frame_start, invalid
   );

endinterface

// File: rtl/bcd_display_scanner_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
//   Combinational BCD nibble to active-high seven-segment pattern.
//   Codes 10..15 are not BCD and show a dash.
//   bcd     in  4  nibble
//   pattern out 7  {g,f,e,d,c,b,a}, active-high
// ---------------------------------------------------------------------------
module bcd_to_seg7
   import bcd_display_scanner_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_DASH;
      case (bcd)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
//   Time-multiplexed common-anode seven-segment driver for NUM_DIGITS packed
//   BCD digits. Once per frame (LOAD) the digits, decimal points, leading-zero
//   mask and invalid flag are captured into shadow registers, so the frame
//   being scanned never mixes old and new counter values.
//   Frame = 1 LOAD cycle + NUM_DIGITS slots of REFRESH_DIV cycles.
//
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   bus.enable   in   scan enable; low idles the scanner and blanks outputs
//   bus.digits_in in  packed BCD, digit 0 = [3:0]
//   bus.dp_in    in   decimal point per digit
//   bus.blank_lz in   leading-zero blanking enable
//   bus.seg      out  {g,f,e,d,c,b,a}, registered
//   bus.dp       out  decimal point, registered
//   bus.an       out  anode selects, registered
//   bus.frame_start out high during every LOAD cycle
//   bus.invalid  out  snapshot contained a nibble > 9
// ---------------------------------------------------------------------------
module bcd_display_scanner
   import bcd_display_scanner_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   bcd_display_scanner_if.slave   bus
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);
   localparam bit SEG_LOW = (SEG_ACTIVE_LOW != 0);
   localparam bit AN_LOW  = (AN_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_LOW}};

   state_t                      state, state_nxt;
   logic [PW-1:0]               pre;
   logic [IW-1:0]               idx;
   logic                        tick;

   logic [NUM_DIGITS-1:0][3:0]  digit_in;
   logic [NUM_DIGITS-1:0][3:0]  digit_sh;
   logic [NUM_DIGITS-1:0]       dp_sh;
   logic [NUM_DIGITS-1:0]       mask_sh;

   logic [NUM_DIGITS-1:0]       lz_mask;
   logic                        lz_run;
   logic                        bad_code;

   logic [NUM_DIGITS-1:0][6:0]  pat;
   logic                        slot_on;
   logic [NUM_DIGITS-1:0]       onehot;

   logic [6:0]                  seg_q;
   logic                        dp_q;
   logic [NUM_DIGITS-1:0]       an_q;
   logic                        inv_q;

   assign digit_in = bus.digits_in;

   // ---------------- FSM ----------------
   assign tick = (state == SCAN) && (pre == PRE_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.enable) state_nxt = LOAD;
         LOAD:    state_nxt = SCAN;
         SCAN:    if (tick && idx == LAST_IDX) state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
      // Dropping enable wins from any state.
      if (!bus.enable) state_nxt = IDLE;
   end

   // ---------------- prescaler / slot index ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
         idx <= '0;
      end else if (state == SCAN) begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick && idx != LAST_IDX) idx <= idx + 1'b1;
      end else begin
         pre <= '0;
         idx <= '0;
      end
   end

   // ---------------- snapshot-derived flags ----------------
   // Walk down from the most significant digit; blanking continues only
   // while digits are zero with no decimal point. Digit 0 always shows.
   always_comb begin
      lz_mask = '0;
      lz_run  = bus.blank_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lz_run && digit_in[i] == 4'd0 && !bus.dp_in[i]) lz_mask[i] = 1'b1;
         else                                               lz_run     = 1'b0;
      end
   end

   always_comb begin
      bad_code = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (digit_in[i] > 4'd9) bad_code = 1'b1;
   end

   // Shadow registers and the flags are all taken from the same LOAD edge,
   // so the mask and invalid bit always describe the digits being shown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_sh <= '0;
         dp_sh    <= '0;
         mask_sh  <= '0;
         inv_q    <= 1'b0;
      end else if (state == LOAD) begin
         digit_sh <= digit_in;
         dp_sh    <= bus.dp_in;
         mask_sh  <= lz_mask;
         inv_q    <= bad_code;
      end else if (state == IDLE) begin
         inv_q    <= 1'b0;
      end
   end

   // ---------------- per-digit decoders ----------------
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      bcd_to_seg7 u_dec (
         .bcd     (digit_sh[g]),
         .pattern (pat[g])
      );
   end

   // ---------------- registered pin drivers ----------------
   assign slot_on = (state == SCAN) && !mask_sh[idx];
   assign onehot  = NUM_DIGITS'(1) << idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= seg_drive(SEG_BLANK, SEG_LOW);
         dp_q  <= SEG_LOW;
         an_q  <= AN_OFF;
      end else if (slot_on) begin
         seg_q <= seg_drive(pat[idx], SEG_LOW);
         dp_q  <= dp_sh[idx] ^ SEG_LOW;
         an_q  <= onehot ^ AN_OFF;
      end else begin
         seg_q <= seg_drive(SEG_BLANK, SEG_LOW);
         dp_q  <= SEG_LOW;
         an_q  <= AN_OFF;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.invalid     = inv_q;
   assign bus.frame_start = (state == LOAD);

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scanner
//   NUM_DIGITS=4, REFRESH_DIV=4, active-low segments and anodes.
//   Each table vector describes one frame: the 17 cycles following the
//   frame_start cycle are queued as expected outputs and popped per cycle.
//   Output timing: the cycle after LOAD is blank, then each slot shows for
//   4 cycles; the last slot's 4th cycle is the next LOAD (frame_start=1).
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bcd_display_scanner_if #(.NUM_DIGITS(4)) bif ();

   bcd_display_scanner #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   typedef struct {
      logic [15:0]      digits;
      logic [3:0]       dpin;
      logic             blz;
      logic [3:0]       lit;     // slots expected lit
      logic [3:0][6:0]  seg;     // pin-level segments per slot
      logic [3:0]       dpo;     // pin-level dp per slot
      logic             inv;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic       inv;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[9];
   vec_t v1234, v12a4, v9999;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_fs(input string nm, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (bif.frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s frame_start: got 0 expected 1 (timeout)", nm);
      end
   endtask

   task automatic push_frame(input vec_t v);
      exp_t       e;
      int         slot;
      logic [3:0] one;
      one = 4'b0001;
      for (int k = 1; k <= 17; k++) begin
         e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
         if (k >= 2) begin
            slot = (k - 2) / 4;
            if (v.lit[slot]) begin
               e.an  = ~(one << slot);
               e.seg = v.seg[slot];
               e.dp  = v.dpo[slot];
            end
         end
         e.fs  = (k == 17);
         e.inv = v.inv;
         sbq.push_back(e);
      end
   endtask

   // Apply a vector, sync to its LOAD, then compare stop_k cycles.
   // At cycle chg_k (after its compare) digits_in is overwritten with chg_d.
   task automatic run_frame(input vec_t v, input string nm, input int chg_k,
                            input logic [15:0] chg_d, input int stop_k);
      bit   ok;
      exp_t e;
      bif.digits_in = v.digits;
      bif.dp_in     = v.dpin;
      bif.blank_lz  = v.blz;
      bif.enable    = 1'b1;
      wait_fs(nm, ok);
      if (!ok) return;
      push_frame(v);
      for (int k = 1; k <= stop_k; k++) begin
         @(negedge clk);
         e = sbq.pop_front();
         chk($sformatf("%s k%0d an", nm, k),  32'(bif.an),          32'(e.an));
         chk($sformatf("%s k%0d seg", nm, k), 32'(bif.seg),         32'(e.seg));
         chk($sformatf("%s k%0d dp", nm, k),  32'(bif.dp),          32'(e.dp));
         chk($sformatf("%s k%0d fs", nm, k),  32'(bif.frame_start), 32'(e.fs));
         chk($sformatf("%s k%0d inv", nm, k), 32'(bif.invalid),     32'(e.inv));
         if (k == chg_k) bif.digits_in = chg_d;
      end
      sbq.delete();
   endtask

   task automatic chk_off(input string nm);
      chk({nm, " an"},  32'(bif.an),  32'hF);
      chk({nm, " seg"}, 32'(bif.seg), 32'h7F);
      chk({nm, " dp"},  32'(bif.dp),  32'h1);
   endtask

   initial begin
      tbl[0] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 1'b0};
      tbl[1] = '{16'h0040, 4'b0000, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111, 1'b0};
      tbl[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 1'b0};
      tbl[3] = '{16'h0000, 4'b0100, 1'b1, 4'b0111, {7'h7F, 7'h40, 7'h40, 7'h40}, 4'b1011, 1'b0};
      tbl[4] = '{16'h12A4, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h3F, 7'h19}, 4'b1111, 1'b1};
      tbl[5] = '{16'h1234, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 1'b0};
      tbl[6] = '{16'h8765, 4'b1001, 1'b1, 4'b1111, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b0110, 1'b0};
      tbl[7] = '{16'h0F00, 4'b0000, 1'b1, 4'b0111, {7'h7F, 7'h3F, 7'h40, 7'h40}, 4'b1111, 1'b1};
      tbl[8] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 1'b0};
      v1234  = tbl[0];
      v12a4  = tbl[4];
      v9999  = '{16'h9999, 4'b0000, 1'b0, 4'b1111, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111, 1'b0};

      // Reset state
      reset         = 1'b1;
      bif.enable    = 1'b0;
      bif.digits_in = '0;
      bif.dp_in     = '0;
      bif.blank_lz  = 1'b0;
      #2;
      chk_off("reset");
      chk("reset fs",  32'(bif.frame_start), 32'h0);
      chk("reset inv", 32'(bif.invalid),     32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven frames, back to back
      for (int i = 0; i < 9; i++)
         run_frame(tbl[i], $sformatf("vec%0d", i), 0, 16'h0, 17);

      // Tear-free capture: digits change while slot 1 is displayed
      run_frame(v1234, "tear", 6, 16'h9999, 17);
      run_frame(v9999, "after_tear", 0, 16'h0, 17);

      // Reset asserted mid-scan with invalid set
      run_frame(v12a4, "pre_rst", 0, 16'h0, 7);
      reset = 1'b1;
      #1;
      chk_off("rst_mid");
      chk("rst_mid fs",  32'(bif.frame_start), 32'h0);
      chk("rst_mid inv", 32'(bif.invalid),     32'h0);
      @(negedge clk);
      chk("rst_hold fs", 32'(bif.frame_start), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release fs", 32'(bif.frame_start), 32'h1);
      run_frame(v1234, "post_rst", 0, 16'h0, 17);

      // Enable drop during slot 2, then restart
      run_frame(v1234, "drop", 0, 16'h0, 10);
      bif.enable = 1'b0;
      @(negedge clk);
      chk("drop+1 an", 32'(bif.an),          32'hB);
      chk("drop+1 fs", 32'(bif.frame_start), 32'h0);
      @(negedge clk);
      chk_off("drop+2");
      chk("drop+2 inv", 32'(bif.invalid), 32'h0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk($sformatf("idle%0d fs", n), 32'(bif.frame_start), 32'h0);
         chk($sformatf("idle%0d an", n), 32'(bif.an),          32'hF);
      end
      run_frame(v1234, "restart", 0, 16'h0, 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumer end of the BCD digit-counter interface. Takes NUM_DIGITS packed BCD digits from the counter chain and drives a time-multiplexed common-anode seven-segment display.
- Takes a tear-free snapshot of the digits once per frame, with optional leading-zero blanking and an invalid-code indication.
- Sits between the counter datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of BCD digits and anodes; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles each digit slot is held; must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 drives segment and dp outputs active-low; 0 drives them active-high.
- AN_ACTIVE_LOW, 1: 1 drives anode outputs active-low; 0 drives them active-high.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  scan enable; low blanks the display and idles the scanner.
- digits_in  in  4*NUM_DIGITS  packed BCD digits; digit 0 = bits [3:0] = least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  leading-zero blanking enable.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  anode selects; one-hot active when a digit is lit.
- frame_start  out  1  one-cycle pulse in every LOAD cycle.
- invalid  out  1  high for the whole frame if any snapshot nibble > 9.

Behaviour:
- Reset (async) state:
  - state = IDLE; prescaler = 0; index = 0; shadow registers = 0.
  - seg, dp and an all at their inactive level (7'h7F / 1 / all-ones when active-low).
  - frame_start = 0; invalid = 0.
- FSM states IDLE, LOAD, SCAN:
  - IDLE: outputs inactive. enable=1 -> LOAD.
  - LOAD (exactly 1 cycle):
    - snapshot digits_in/dp_in into the shadow registers;
    - compute the blanking mask and invalid flag from the snapshot;
    - index = 0, prescaler = 0, frame_start = 1;
    - -> SCAN.
  - SCAN:
    - prescaler increments each cycle; at REFRESH_DIV-1 it wraps to 0 (tick).
    - On tick: index < NUM_DIGITS-1 -> index+1; index == NUM_DIGITS-1 -> LOAD.
- enable=0 in any state -> IDLE on the next edge. The IDLE-state outputs are inactive from the cycle after that.
- Frame period = 1 + NUM_DIGITS*REFRESH_DIV cycles.
- Output timing: seg/dp/an are registered from (state, index, shadow). They reflect a state/index change 1 cycle later.
- Digit slot, SCAN state, digit not blanked:
  - an = one-hot on index;
  - seg = decode(shadow[index]);
  - dp = dp_shadow[index].
- Blanked slot: an, seg and dp all inactive.
- Leading-zero mask:
  - With blank_lz=1, digits from NUM_DIGITS-1 downward are blanked while they equal 0 and dp_shadow is 0.
  - Blanking stops at the first nonzero digit or set dp.
  - Digit 0 is never blanked.
- Decode, active-high values:
  - digits 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F;
  - codes 10..15 = dash (40);
  - output is inverted when SEG_ACTIVE_LOW=1.
- invalid: registered in LOAD; holds until the next LOAD or IDLE; cleared in IDLE.
- Mid-frame changes to digits_in, dp_in or blank_lz have no effect until the next LOAD.
- Reset asserted mid-scan forces the reset values immediately. After release, enable=1 -> LOAD on the first edge.

Decomposition:
- Shared package holds:
  - seven-segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - state encoding (IDLE=2'd0, LOAD=2'd1, SCAN=2'd2).
- One sub-module, bcd_to_seg7: combinational nibble -> 7-bit active-high pattern, dash for 10..15.
- Scanner FSM, prescaler, shadow registers and blanking logic stay in bcd_display_scanner.

Test Plan:
All cases use NUM_DIGITS=4, REFRESH_DIV=4, active-low outputs.
- Reset: reset=1 with enable=1 mid-scan -> same cycle an=4'hF, seg=7'h7F, dp=1, frame_start=0. Release -> frame_start pulses on the next edge.
- Basic scan: digits_in=16'h1234, dp_in=0, blank_lz=0, enable rises -> frame_start for 1 cycle, then for 4 cycles each:
  - an=1110, seg=7'h19;
  - then an=1101, seg=7'h30;
  - then an=1011, seg=7'h24;
  - then an=0111, seg=7'h79.
  - Next frame_start follows 17 cycles after the previous one.
- Blanking: digits_in=16'h0040, blank_lz=1:
  - slots 3 and 2 have an=1111;
  - slot 1 has seg=7'h19; slot 0 has seg=7'h40.
  - Then digits_in=16'h0000 -> only slot 0 lit, seg=7'h40.
  - With dp_in=4'b0100 -> slot 2 lit with seg=7'h40, dp=0.
- Tear-free capture: change digits_in from 16'h1234 to 16'h9999 during slot 1 -> slots 1..3 still show 3,2,1. The next frame shows 9 in every slot.
- Invalid: digits_in=16'h12A4 -> invalid=1 from the cycle after LOAD for the whole frame, and slot 1 shows dash seg=7'h3F. After restoring 16'h1234, invalid=0 after the next LOAD.
- Enable drop: enable=0 during slot 2 -> state IDLE on the next edge, an=1111 one cycle later. enable=1 again -> a fresh LOAD restarts at slot 0.
